// File: rtl/dsec_ctrl_pkg.sv
// Shared definitions for the DSEC flow controller: FSM state encoding and latched error codes.
package dsec_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    KEYCFG,
    EMIT,
    DUMP,
    ERROR
  } state_t;

  localparam logic [7:0] ERR_NONE    = 8'h00;
  localparam logic [7:0] ERR_PROTO   = 8'h01;
  localparam logic [7:0] ERR_OVERRUN = 8'h02;
  localparam logic [7:0] ERR_TIMEOUT = 8'h03;

endpackage

// File: rtl/dsec_wdog.sv
// Output watchdog: counts enabled cycles and flags the TIMEOUT-th one; only instantiated when TIMEOUT > 0.
module dsec_wdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Combinational flag so the FSM can act on the very edge that completes TIMEOUT waiting cycles.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dsec_flow_ctrl.sv
// DSEC top-level control FSM: stall/rdy generation, output handshake, end-of-stream dump,
// key-config hold, first-wins error latch and accepted-word counter. All outputs registered.
module dsec_flow_ctrl
  import dsec_ctrl_pkg::*;
#(
  parameter int unsigned ERR_W    = 64,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TIMEOUT  = 256,
  parameter bit          ENCRY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_config,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             out_rcvd,
  input  logic             shcn_done,
  input  logic             comp_rdy,
  input  logic             encry_rdy,
  input  logic             comp_flushed,
  input  logic             error_clr,
  output logic             stall,
  output logic             rdy,
  output logic             out_valid,
  output logic             dump_comp,
  output logic             error,
  output logic [ERR_W-1:0] error_code,
  output logic [CNT_W-1:0] word_count
);

  state_t           state, ns;
  logic             dump_pend;
  logic             eng_rdy;
  logic             wd_expired;
  logic             accept, set_pend, clr_pend;
  logic [7:0]       det;
  logic [ERR_W-9:0] snap;

  assign eng_rdy = comp_rdy && (encry_rdy || !ENCRY_EN);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic wd_en, wd_clr;
      assign wd_en  = (state == EMIT) && !out_rcvd;
      assign wd_clr = (state != EMIT) || out_rcvd;
      dsec_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (wd_expired)
      );
    end else begin : g_no_wdog
      assign wd_expired = 1'b0;
    end

    if (CNT_W >= ERR_W - 8) begin : g_snap_trunc
      assign snap = word_count[ERR_W-9:0];
    end else begin : g_snap_ext
      assign snap = {{(ERR_W - 8 - CNT_W){1'b0}}, word_count};
    end
  endgenerate

  // Error detection overrides every other transition; ERROR never sets det, so the first code sticks.
  always_comb begin
    ns       = state;
    det      = ERR_NONE;
    accept   = 1'b0;
    set_pend = 1'b0;
    clr_pend = 1'b0;
    case (state)
      IDLE: if (eng_rdy && !key_config) ns = RUN;
      RUN: begin
        if (in_valid && !rdy)                   det = ERR_PROTO;
        else if (key_config)                    ns  = KEYCFG;
        else if (shcn_done)                     ns  = EMIT;
        else if (in_valid && in_last && rdy) begin
          ns       = DUMP;
          set_pend = 1'b1;
        end
      end
      KEYCFG: if (!key_config) ns = RUN;
      EMIT: begin
        if (shcn_done && !out_rcvd) det = ERR_OVERRUN;
        else if (wd_expired)        det = ERR_TIMEOUT;
        else if (out_rcvd) begin
          accept = 1'b1;
          if (key_config)     ns = KEYCFG;
          else if (shcn_done) ns = EMIT;
          else if (dump_pend) ns = DUMP;
          else                ns = RUN;
        end
      end
      DUMP: begin
        if (shcn_done) ns = EMIT;
        else if (comp_flushed) begin
          ns       = IDLE;
          clr_pend = 1'b1;
        end
      end
      ERROR: if (error_clr) ns = IDLE;
      default: ns = IDLE;
    endcase
    if (det != ERR_NONE) ns = ERROR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      stall      <= 1'b1;
      rdy        <= 1'b0;
      out_valid  <= 1'b0;
      dump_comp  <= 1'b0;
      error      <= 1'b0;
      error_code <= '0;
      word_count <= '0;
      dump_pend  <= 1'b0;
    end else begin
      state     <= ns;
      stall     <= 1'b1;
      rdy       <= 1'b0;
      out_valid <= 1'b0;
      dump_comp <= 1'b0;
      case (ns)
        RUN: begin
          rdy   <= eng_rdy;
          stall <= !in_valid;
        end
        EMIT: out_valid <= 1'b1;
        // Only the RUN->DUMP entry starts a dump; returning from EMIT continues the same one.
        DUMP: dump_comp <= (state == RUN);
        default: ;
      endcase
      if (accept) word_count <= word_count + 1'b1;
      if (set_pend)      dump_pend <= 1'b1;
      else if (clr_pend) dump_pend <= 1'b0;
      if (det != ERR_NONE) begin
        error      <= 1'b1;
        error_code <= {snap, det};
      end else if (state == ERROR && error_clr) begin
        error      <= 1'b0;
        error_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dsec_flow_ctrl.sv
// Directed bench for dsec_flow_ctrl: one instance with a short watchdog, one with encryption
// bypassed, a 2-bit word counter and a 16-bit error code.
module tb_dsec_flow_ctrl;

  logic clk = 1'b0;
  logic rst, key_config, in_valid, in_last, out_rcvd, shcn_done;
  logic comp_rdy, encry_rdy, comp_flushed, error_clr;

  logic        a_stall, a_rdy, a_out_valid, a_dump_comp, a_error;
  logic [63:0] a_error_code;
  logic [31:0] a_word_count;

  logic        b_stall, b_rdy, b_out_valid, b_dump_comp, b_error;
  logic [15:0] b_error_code;
  logic [1:0]  b_word_count;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  dsec_flow_ctrl #(.ERR_W(64), .CNT_W(32), .TIMEOUT(4), .ENCRY_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .key_config(key_config), .in_valid(in_valid), .in_last(in_last),
    .out_rcvd(out_rcvd), .shcn_done(shcn_done), .comp_rdy(comp_rdy), .encry_rdy(encry_rdy),
    .comp_flushed(comp_flushed), .error_clr(error_clr),
    .stall(a_stall), .rdy(a_rdy), .out_valid(a_out_valid), .dump_comp(a_dump_comp),
    .error(a_error), .error_code(a_error_code), .word_count(a_word_count)
  );

  dsec_flow_ctrl #(.ERR_W(16), .CNT_W(2), .TIMEOUT(0), .ENCRY_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .key_config(key_config), .in_valid(in_valid), .in_last(in_last),
    .out_rcvd(out_rcvd), .shcn_done(shcn_done), .comp_rdy(comp_rdy), .encry_rdy(encry_rdy),
    .comp_flushed(comp_flushed), .error_clr(error_clr),
    .stall(b_stall), .rdy(b_rdy), .out_valid(b_out_valid), .dump_comp(b_dump_comp),
    .error(b_error), .error_code(b_error_code), .word_count(b_word_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; key_config = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_rcvd = 1'b0;
    shcn_done = 1'b0; comp_rdy = 1'b0; encry_rdy = 1'b0; comp_flushed = 1'b0; error_clr = 1'b0;
    tick(); tick();
    chk("rst_stall", a_stall, 1);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_dump_comp", a_dump_comp, 0);
    chk("rst_error", a_error, 0);
    chk("rst_error_code", a_error_code, 0);
    chk("rst_word_count", a_word_count, 0);

    // IDLE -> RUN, stall follows in_valid
    rst = 1'b1; comp_rdy = 1'b1; encry_rdy = 1'b1;
    tick();
    chk("run_rdy", a_rdy, 1);
    chk("run_stall_idle", a_stall, 1);
    in_valid = 1'b1; tick();
    chk("run_stall_valid", a_stall, 0);
    in_valid = 1'b0; tick();
    chk("run_stall_back", a_stall, 1);

    // One word, receiver waits three cycles
    shcn_done = 1'b1; tick(); shcn_done = 1'b0;
    chk("emit_rdy", a_rdy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("emit_hold", a_out_valid, 1);
      tick();
    end
    chk("emit_hold4", a_out_valid, 1);
    out_rcvd = 1'b1; tick(); out_rcvd = 1'b0;
    chk("acc_out_valid", a_out_valid, 0);
    chk("acc_word_count", a_word_count, 1);
    chk("acc_rdy", a_rdy, 1);
    chk("acc_error", a_error, 0);

    // End of stream: dump, residual word, flush
    in_valid = 1'b1; in_last = 1'b1; tick(); in_valid = 1'b0; in_last = 1'b0;
    chk("dump_pulse", a_dump_comp, 1);
    chk("dump_rdy", a_rdy, 0);
    tick();
    chk("dump_pulse_end", a_dump_comp, 0);
    shcn_done = 1'b1; tick(); shcn_done = 1'b0;
    chk("dump_emit", a_out_valid, 1);
    out_rcvd = 1'b1; tick(); out_rcvd = 1'b0;
    chk("dump_wc", a_word_count, 2);
    chk("dump_no_repulse", a_dump_comp, 0);
    chk("dump_back_stall", a_stall, 1);
    comp_flushed = 1'b1; tick(); comp_flushed = 1'b0;
    chk("flush_idle_rdy", a_rdy, 0);
    tick();
    chk("idle_to_run", a_rdy, 1);

    // key_config during EMIT is deferred until the handshake
    shcn_done = 1'b1; tick(); shcn_done = 1'b0;
    key_config = 1'b1; tick();
    chk("kc_emit_hold", a_out_valid, 1);
    out_rcvd = 1'b1; tick(); out_rcvd = 1'b0;
    chk("kc_out_valid", a_out_valid, 0);
    chk("kc_stall", a_stall, 1);
    chk("kc_wc", a_word_count, 3);
    tick();
    chk("kc_hold_rdy", a_rdy, 0);
    key_config = 1'b0; tick();
    chk("kc_release_rdy", a_rdy, 1);

    // Watchdog expiry after four waiting cycles
    shcn_done = 1'b1; tick(); shcn_done = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("wd_pre_error", a_error, 0);
    tick();
    chk("wd_error", a_error, 1);
    chk("wd_code", a_error_code, 64'h303);
    chk("wd_out_valid", a_out_valid, 0);
    tick();
    chk("wd_sticky", a_error_code, 64'h303);
    error_clr = 1'b1; tick(); error_clr = 1'b0;
    chk("clr_error", a_error, 0);
    chk("clr_code", a_error_code, 0);
    chk("clr_wc_kept", a_word_count, 3);
    tick();

    // PROTO: input offered while not ready; later events ignored while in ERROR
    comp_rdy = 1'b0; tick();
    chk("proto_rdy_low", a_rdy, 0);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    chk("proto_code", a_error_code, 64'h301);
    comp_rdy = 1'b1; shcn_done = 1'b1; tick(); shcn_done = 1'b0;
    chk("proto_first_wins", a_error_code, 64'h301);
    error_clr = 1'b1; tick(); error_clr = 1'b0;
    tick();

    // OVERRUN: shcn_done again before the pending word is taken
    shcn_done = 1'b1; tick(); tick(); shcn_done = 1'b0;
    chk("overrun_code", a_error_code, 64'h302);

    // Second instance: encryption bypass, counter wrap, narrow error code
    rst = 1'b0; error_clr = 1'b0; tick();
    rst = 1'b1; comp_rdy = 1'b1; encry_rdy = 1'b0; tick();
    chk("byp_rdy", b_rdy, 1);
    chk("enc_gated_rdy", a_rdy, 0);
    for (int i = 0; i < 5; i++) begin
      shcn_done = 1'b1; tick(); shcn_done = 1'b0;
      out_rcvd = 1'b1; tick(); out_rcvd = 1'b0;
      if (i == 3) chk("wrap_wc4", b_word_count, 0);
    end
    chk("wrap_wc5", b_word_count, 1);
    shcn_done = 1'b1; tick(); tick(); shcn_done = 1'b0;
    chk("narrow_code", b_error_code, 16'h0102);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
